sort_job_controller: RTL and testbench

Sequences one complete sort job around the merge-sort engine and its shared data memory. It accepts a job command with a length, streams input bytes into memory, hands the memory to the engine, and waits for its done. It then reclaims the memory and streams the sorted bytes out over a valid/ready interface. It is the only master arbitrating memory ownership between the host-side streams and the engine.

---
 rtl/sort_job_controller_if.sv | 46 ++++
 rtl/sort_job_controller.sv | 127 ++++++++++++
 tb/tb_sort_job_controller.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_job_controller_if.sv
// Handshake, engine and memory-port signals of the sort job controller.
// The controller takes the master view; the host/engine/memory side takes the slave view.
interface sort_job_controller_if #(
  parameter int N     = 1024,
  parameter int LOG2N = 10,
  parameter int W     = 8
) ();

  logic             cmd_valid;
  logic [LOG2N:0]   cmd_len;
  logic             cmd_ready;

  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;

  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             out_ready;

  logic             sort_start;
  logic             sort_done;
  logic             eng_own;

  logic             mem_we;
  logic [LOG2N-1:0] mem_addr;
  logic [W-1:0]     mem_wdata;
  logic [W-1:0]     mem_rdata;

  logic             job_done;
  logic             cmd_err;
  logic             busy;

  modport master (
    input  cmd_valid, cmd_len, in_valid, in_data, out_ready, sort_done, mem_rdata,
    output cmd_ready, in_ready, out_valid, out_data, sort_start, eng_own,
           mem_we, mem_addr, mem_wdata, job_done, cmd_err, busy
  );

  modport slave (
    output cmd_valid, cmd_len, in_valid, in_data, out_ready, sort_done, mem_rdata,
    input  cmd_ready, in_ready, out_valid, out_data, sort_start, eng_own,
           mem_we, mem_addr, mem_wdata, job_done, cmd_err, busy
  );

endinterface

// File: rtl/sort_job_controller.sv
// Runs one sort job: load elements into the shared memory, hand it to the merge-sort
// engine, reclaim it on sort_done and stream the sorted elements back out.
module sort_job_controller #(
  parameter int N     = 1024,
  parameter int LOG2N = 10,
  parameter int W     = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  sort_job_controller_if.master bus
);

  typedef enum logic [2:0] {IDLE, LOAD, KICK, SORT, RD, OUT} state_e;

  localparam logic [LOG2N:0] MAX_LEN = (LOG2N + 1)'(N);
  localparam logic [LOG2N:0] ONE     = (LOG2N + 1)'(1);

  state_e         state_q, state_d;
  logic [LOG2N:0] len_q, len_d;
  logic [LOG2N:0] ptr_q, ptr_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic           job_done_q, job_done_d;
  logic           cmd_err_q, cmd_err_d;
  logic           sort_start_q, eng_own_q, out_valid_q, busy_q;
  logic           last_elem;

  // ptr and len carry one extra bit so a full-depth job never wraps.
  assign last_elem = (ptr_q == len_q - ONE);

  // NOTE: every variable gets its default before the case so no path leaves one
  // unassigned; an incomplete assignment here would infer a latch.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    ptr_d      = ptr_q;
    out_data_d = out_data_q;
    job_done_d = 1'b0;
    cmd_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_len > MAX_LEN) begin
            cmd_err_d = 1'b1;
          end else if (bus.cmd_len == '0) begin
            job_done_d = 1'b1;
          end else begin
            len_d   = bus.cmd_len;
            ptr_d   = '0;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          ptr_d = ptr_q + ONE;
          if (last_elem) state_d = KICK;
        end
      end
      KICK: state_d = SORT;
      SORT: begin
        if (bus.sort_done) begin
          ptr_d   = '0;
          state_d = RD;
        end
      end
      RD: begin
        out_data_d = bus.mem_rdata;
        state_d    = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          if (last_elem) begin
            job_done_d = 1'b1;
            state_d    = IDLE;
          end else begin
            ptr_d   = ptr_q + ONE;
            state_d = RD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values; registered outputs are decoded from state_d to line up with state_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      ptr_q        <= '0;
      out_data_q   <= '0;
      job_done_q   <= 1'b0;
      cmd_err_q    <= 1'b0;
      sort_start_q <= 1'b0;
      eng_own_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      ptr_q        <= ptr_d;
      out_data_q   <= out_data_d;
      job_done_q   <= job_done_d;
      cmd_err_q    <= cmd_err_d;
      sort_start_q <= (state_d == KICK);
      eng_own_q    <= (state_d == KICK) || (state_d == SORT);
      out_valid_q  <= (state_d == OUT);
      busy_q       <= (state_d != IDLE);
    end
  end

  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.in_ready   = (state_q == LOAD);
  assign bus.mem_we     = bus.in_ready && bus.in_valid;
  assign bus.mem_wdata  = bus.mem_we ? bus.in_data : '0;
  assign bus.mem_addr   = ptr_q[LOG2N-1:0];
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.sort_start = sort_start_q;
  assign bus.eng_own    = eng_own_q;
  assign bus.job_done   = job_done_q;
  assign bus.cmd_err    = cmd_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sort_job_controller.sv
// Bench for sort_job_controller: command-response table, directed corner sequences and
// randomized jobs compared against a sorted-queue reference with a behavioural engine.
module tb_sort_job_controller;

  localparam int N     = 1024;
  localparam int LOG2N = 10;
  localparam int W     = 8;
  localparam int DELAY = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sort_job_controller_if #(.N(N), .LOG2N(LOG2N), .W(W)) bus ();

  sort_job_controller #(.N(N), .LOG2N(LOG2N), .W(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Shared memory plus a behavioural engine that sorts elements 0..eng_len-1 and
  // raises sort_done DELAY cycles after it sees sort_start.
  logic [W-1:0] mem [N];
  logic [W-1:0] eng_q[$];
  logic         eng_done_q = 1'b0;
  logic         sd_force   = 1'b0;
  logic         eng_auto   = 1'b1;
  int           eng_cnt    = 0;
  int           eng_len    = 0;

  assign bus.sort_done = eng_done_q | sd_force;
  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clock) begin
    if (bus.mem_we && !bus.eng_own) mem[bus.mem_addr] <= bus.mem_wdata;
    if (reset) begin
      eng_cnt    <= 0;
      eng_done_q <= 1'b0;
    end else begin
      eng_done_q <= 1'b0;
      if (bus.sort_start && eng_auto) begin
        eng_cnt <= DELAY - 1;
      end else if (eng_cnt > 0) begin
        eng_cnt <= eng_cnt - 1;
        if (eng_cnt == 1) begin
          eng_done_q <= 1'b1;
          eng_q = {};
          for (int i = 0; i < eng_len; i++) eng_q.push_back(mem[i]);
          eng_q.sort();
          for (int i = 0; i < eng_len; i++) mem[i] <= eng_q[i];
        end
      end
    end
  end

  // Event counters sampled mid-cycle.
  int n_start = 0, n_done = 0, n_err = 0, n_we = 0, own_cyc = 0, own_viol = 0;
  always @(negedge clock) begin
    if (bus.sort_start) n_start++;
    if (bus.job_done)   n_done++;
    if (bus.cmd_err)    n_err++;
    if (bus.mem_we)     n_we++;
    if (bus.eng_own)    own_cyc++;
    if ((bus.eng_own && bus.mem_we) || (bus.sort_start && !bus.eng_own)) own_viol++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] stim_q[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input int len);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = (LOG2N + 1)'(len);
    eng_len       = len;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic load(input int len, input int gap, input int sd_at, output int err);
    int  idx   = 0;
    int  guard = 0;
    bit  hs;
    err = 0;
    while (idx < len && guard < 100 + 10 * len) begin
      bus.in_valid = ($urandom_range(99) >= gap);
      bus.in_data  = stim_q[idx];
      sd_force     = (guard == sd_at);
      #1;
      hs = bus.in_valid && bus.in_ready;
      if (hs && (!bus.mem_we || int'(bus.mem_addr) != idx || bus.mem_wdata != stim_q[idx])) err++;
      if (!hs && bus.mem_we) err++;
      tick();
      if (hs) idx++;
      guard++;
    end
    bus.in_valid = 1'b0;
    sd_force     = 1'b0;
    if (idx != len) err++;
  endtask

  task automatic drain(input int len, input int bp, input int hold,
                       output logic [W-1:0] got[$], output int stab_err, output bit done);
    int           held      = 0;
    bit           stall_prev = 1'b0;
    logic [W-1:0] data_prev = '0;
    got = {};
    stab_err = 0;
    done = 1'b0;
    for (int c = 0; c < 200 + 20 * len && !done; c++) begin
      if (stall_prev && (!bus.out_valid || bus.out_data !== data_prev)) stab_err++;
      if (bus.out_valid && held < hold) begin
        bus.out_ready = 1'b0;
        held++;
      end else begin
        bus.out_ready = ($urandom_range(99) >= bp);
      end
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
      stall_prev = bus.out_valid && !bus.out_ready;
      data_prev  = bus.out_data;
      tick();
      if (bus.job_done) done = 1'b1;
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic compare(input string tag, input logic [W-1:0] got[$], input logic [W-1:0] exp[$]);
    check($sformatf("%s count", tag), got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s elem%0d", tag, i), int'(got[i]), int'(exp[i]));
  endtask

  task automatic run_job(input int len, input int gap, input int bp, input int hold,
                         input int sd_at, input string tag);
    int           s0, d0, o0, w0, v0, lerr, serr;
    bit           done;
    logic [W-1:0] got[$];
    logic [W-1:0] exp[$];
    s0 = n_start; d0 = n_done; o0 = own_cyc; w0 = n_we; v0 = own_viol;
    send_cmd(len);
    load(len, gap, sd_at, lerr);
    drain(len, bp, hold, got, serr, done);
    tick();
    exp = stim_q;
    exp.sort();
    check($sformatf("%s finished", tag), int'(done), 1);
    compare(tag, got, exp);
    check($sformatf("%s load writes", tag), lerr, 0);
    check($sformatf("%s we count", tag), n_we - w0, len);
    check($sformatf("%s sort_start", tag), n_start - s0, 1);
    check($sformatf("%s job_done", tag), n_done - d0, 1);
    check($sformatf("%s eng_own cycles", tag), own_cyc - o0, DELAY + 1);
    check($sformatf("%s ownership", tag), own_viol - v0, 0);
    check($sformatf("%s out stable", tag), serr, 0);
    check($sformatf("%s idle after", tag), int'(bus.cmd_ready), 1);
  endtask

  task automatic rand_stim(input int len);
    stim_q = {};
    for (int i = 0; i < len; i++) stim_q.push_back(W'($urandom_range(255)));
  endtask

  typedef struct {
    int len;
    bit err;
    bit done;
    bit busy;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int           s0, d0, o0, w0, lerr, serr;
    bit           done;
    logic [W-1:0] got[$];

    vecs[0] = '{len: 0,    err: 1'b0, done: 1'b1, busy: 1'b0};
    vecs[1] = '{len: 1025, err: 1'b1, done: 1'b0, busy: 1'b0};
    vecs[2] = '{len: 2047, err: 1'b1, done: 1'b0, busy: 1'b0};
    vecs[3] = '{len: 1024, err: 1'b0, done: 1'b0, busy: 1'b1};
    vecs[4] = '{len: 1,    err: 1'b0, done: 1'b0, busy: 1'b1};
    vecs[5] = '{len: 0,    err: 1'b0, done: 1'b1, busy: 1'b0};

    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    check("rst cmd_ready", int'(bus.cmd_ready), 1);
    check("rst busy", int'(bus.busy), 0);
    check("rst eng_own", int'(bus.eng_own), 0);
    check("rst out_valid", int'(bus.out_valid), 0);
    check("rst sort_start", int'(bus.sort_start), 0);
    check("rst job_done", int'(bus.job_done), 0);
    check("rst cmd_err", int'(bus.cmd_err), 0);
    check("rst in_ready", int'(bus.in_ready), 0);
    check("rst mem_addr", int'(bus.mem_addr), 0);
    reset = 1'b0;
    tick();

    // Command acceptance table.
    foreach (vecs[v]) begin
      s0 = n_start; w0 = n_we;
      send_cmd(vecs[v].len);
      check($sformatf("vec%0d cmd_err", v), int'(bus.cmd_err), int'(vecs[v].err));
      check($sformatf("vec%0d job_done", v), int'(bus.job_done), int'(vecs[v].done));
      check($sformatf("vec%0d busy", v), int'(bus.busy), int'(vecs[v].busy));
      check($sformatf("vec%0d cmd_ready", v), int'(bus.cmd_ready), int'(!vecs[v].busy));
      tick();
      check($sformatf("vec%0d pulse end", v), int'(bus.cmd_err || bus.job_done), 0);
      check($sformatf("vec%0d no start", v), n_start - s0, 0);
      check($sformatf("vec%0d no we", v), n_we - w0, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
    end

    // Basic job from the plan: 5,3,9,1 -> 1,3,5,9.
    stim_q = '{8'd5, 8'd3, 8'd9, 8'd1};
    run_job(4, 0, 0, 0, -1, "job4");

    // Rejected command followed by a normal job.
    send_cmd(N + 1);
    check("reject busy", int'(bus.busy), 0);
    check("reject err", int'(bus.cmd_err), 1);
    tick();
    rand_stim(2);
    run_job(2, 0, 0, 0, -1, "after_err");

    // Output held off for 10 cycles on the first element.
    rand_stim(3);
    run_job(3, 0, 0, 10, -1, "hold");

    // Reset in LOAD after two of four writes.
    rand_stim(4);
    d0 = n_done;
    send_cmd(4);
    bus.in_valid = 1'b1;
    bus.in_data  = stim_q[0];
    tick();
    bus.in_data  = stim_q[1];
    tick();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstload busy", int'(bus.busy), 0);
    check("rstload cmd_ready", int'(bus.cmd_ready), 1);
    check("rstload in_ready", int'(bus.in_ready), 0);
    repeat (3) tick();
    check("rstload no job_done", n_done - d0, 0);
    rand_stim(4);
    run_job(4, 0, 0, 0, -1, "after_rstload");

    // Reset while the engine owns memory.
    rand_stim(2);
    d0 = n_done;
    send_cmd(2);
    load(2, 0, -1, lerr);
    repeat (5) tick();
    check("rstsort owned", int'(bus.eng_own), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstsort eng_own", int'(bus.eng_own), 0);
    check("rstsort busy", int'(bus.busy), 0);
    repeat (30) tick();
    check("rstsort no job_done", n_done - d0, 0);
    rand_stim(4);
    run_job(4, 0, 0, 0, -1, "after_rstsort");

    // sort_done in IDLE, then in LOAD: neither may be taken.
    sd_force = 1'b1;
    tick();
    sd_force = 1'b0;
    check("sd idle busy", int'(bus.busy), 0);
    check("sd idle own", int'(bus.eng_own), 0);
    rand_stim(3);
    run_job(3, 0, 0, 0, 1, "sd_load");

    // sort_done already high in KICK: skipped there, taken on the first SORT cycle.
    eng_auto = 1'b0;
    stim_q = '{8'd7, 8'd2};
    o0 = own_cyc; d0 = n_done;
    send_cmd(2);
    load(2, 0, -1, lerr);
    sd_force = 1'b1;
    check("kick sort_start", int'(bus.sort_start), 1);
    check("kick eng_own", int'(bus.eng_own), 1);
    tick();
    check("kick->sort own", int'(bus.eng_own), 1);
    check("kick->sort start", int'(bus.sort_start), 0);
    tick();
    sd_force = 1'b0;
    check("sort taken own", int'(bus.eng_own), 0);
    drain(2, 0, 0, got, serr, done);
    tick();
    check("kick finished", int'(done), 1);
    compare("kick", got, stim_q);
    check("kick own cycles", own_cyc - o0, 2);
    check("kick job_done", n_done - d0, 1);
    eng_auto = 1'b1;

    // Randomized jobs, a single-element job and a full-depth job.
    for (int j = 0; j < 6; j++) begin
      int len;
      len = $urandom_range(1, 16);
      rand_stim(len);
      run_job(len, $urandom_range(0, 40), $urandom_range(0, 50), 0, -1, $sformatf("rand%0d", j));
    end
    rand_stim(1);
    run_job(1, 20, 30, 0, -1, "len1");
    rand_stim(N);
    run_job(N, 0, 0, 0, -1, "lenN");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
